// File: rtl/simd_two24_frame_accum_if.sv
// Bundle for the two-lane frame accumulator: clock enable, frame length, packed input
// stream and per-lane frame result stream.
interface simd_two24_frame_accum_if #(
  parameter int ACC_W = 32,
  parameter int LEN_W = 16
);
  logic                    ap_ce;
  logic [LEN_W-1:0]        len;
  logic                    in_valid;
  logic                    in_ready;
  logic [47:0]             in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_lane0;
  logic signed [ACC_W-1:0] out_lane1;
  logic [1:0]              out_sat;

  modport master (
    output ap_ce, len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_lane0, out_lane1, out_sat
  );

  modport slave (
    input  ap_ce, len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_lane0, out_lane1, out_sat
  );
endinterface

// File: rtl/simd_two24_frame_accum.sv
// Unpacks two signed 24-bit lanes, accumulates each over a frame of len beats with
// saturation, and holds one frame result in a valid/ready output register.
module simd_two24_frame_accum #(
  parameter int ACC_W = 32,
  parameter int LEN_W = 16
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  simd_two24_frame_accum_if.slave  bus
);

  typedef enum logic {S_FIRST, S_ACCUM} state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [LEN_W-1:0]        LEN_ONE = LEN_W'(1);

  function automatic logic signed [ACC_W:0] lane_add(input logic signed [ACC_W-1:0] a,
                                                     input logic signed [23:0]      b);
    return {a[ACC_W-1], a} + {{(ACC_W-23){b[23]}}, b};
  endfunction

  function automatic logic sat_ovf(input logic signed [ACC_W:0] s);
    return s[ACC_W] ^ s[ACC_W-1];
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_clamp(input logic signed [ACC_W:0] s);
    if (sat_ovf(s)) return s[ACC_W] ? ACC_MIN : ACC_MAX;
    return s[ACC_W-1:0];
  endfunction

  state_t                  r_state;
  logic signed [ACC_W-1:0] r_acc0, r_acc1;
  logic [1:0]              r_sat;
  logic [LEN_W-1:0]        r_len_q, r_beat_cnt;
  logic                    r_out_valid;
  logic signed [ACC_W-1:0] r_out_lane0, r_out_lane1;
  logic [1:0]              r_out_sat;

  logic                    w_first, w_last, w_in_ready, w_take, w_done, w_xfer;
  logic [LEN_W-1:0]        w_len_eff, w_cnt_nxt;
  logic signed [ACC_W-1:0] w_base0, w_base1, w_nacc0, w_nacc1;
  logic signed [ACC_W:0]   w_sum0, w_sum1;
  logic [1:0]              w_sat_nxt;

  assign w_first   = (r_state == S_FIRST);
  assign w_len_eff = (bus.len == '0) ? LEN_ONE : bus.len;
  assign w_cnt_nxt = w_first ? LEN_ONE : r_beat_cnt + LEN_ONE;
  // In FIRST the frame length comes straight from the input, since len_q is not yet loaded.
  assign w_last    = w_first ? (w_len_eff == LEN_ONE) : (w_cnt_nxt == r_len_q);

  assign w_in_ready = bus.ap_ce & ~(r_out_valid & ~bus.out_ready & w_last);
  assign w_take     = bus.in_valid & w_in_ready;
  assign w_done     = w_take & w_last;
  assign w_xfer     = r_out_valid & bus.out_ready;

  assign w_base0   = w_first ? '0 : r_acc0;
  assign w_base1   = w_first ? '0 : r_acc1;
  assign w_sum0    = lane_add(w_base0, bus.in_data[47:24]);
  assign w_sum1    = lane_add(w_base1, bus.in_data[23:0]);
  assign w_nacc0   = sat_clamp(w_sum0);
  assign w_nacc1   = sat_clamp(w_sum1);
  assign w_sat_nxt = (w_first ? 2'b00 : r_sat) | {sat_ovf(w_sum1), sat_ovf(w_sum0)};

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state     <= S_FIRST;
      r_acc0      <= '0;
      r_acc1      <= '0;
      r_sat       <= '0;
      r_len_q     <= '0;
      r_beat_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_lane0 <= '0;
      r_out_lane1 <= '0;
      r_out_sat   <= '0;
    end else begin
      if (w_take) begin
        r_acc0     <= w_nacc0;
        r_acc1     <= w_nacc1;
        r_sat      <= w_sat_nxt;
        r_beat_cnt <= w_cnt_nxt;
        if (w_first) r_len_q <= w_len_eff;
        r_state    <= w_last ? S_FIRST : S_ACCUM;
      end
      // A completing frame wins over a transfer so back-to-back results are never lost.
      if (w_done) begin
        r_out_valid <= 1'b1;
        r_out_lane0 <= w_nacc0;
        r_out_lane1 <= w_nacc1;
        r_out_sat   <= w_sat_nxt;
      end else if (w_xfer) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_lane0 = r_out_lane0;
  assign bus.out_lane1 = r_out_lane1;
  assign bus.out_sat   = r_out_sat;

endmodule

// File: tb/tb_simd_two24_frame_accum.sv
// Directed bench for simd_two24_frame_accum with hand-computed frame totals.
module tb_simd_two24_frame_accum;
  localparam int ACC_W = 25;
  localparam int LEN_W = 16;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;
  int   n_chk    = 0;
  int   n_fail   = 0;
  int   waits;

  simd_two24_frame_accum_if #(.ACC_W(ACC_W), .LEN_W(LEN_W)) bus();

  simd_two24_frame_accum #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus.slave)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Presents one beat and waits (bounded) until it is accepted; returns stall cycles.
  task automatic beat(input logic signed [23:0] a, input logic signed [23:0] b,
                      output int nwait);
    nwait = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = {a, b};
    #1;
    while (!bus.in_ready && nwait < 50) begin
      @(posedge ap_clk);
      #2;
      nwait++;
    end
    if (nwait >= 50) check("beat_timeout", 64'(nwait), 64'(0));
    else begin
      @(posedge ap_clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic v, input int l0, input int l1,
                           input logic [1:0] s);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'(v));
    check({tag, "_lane0"}, 64'(bus.out_lane0), 64'(l0));
    check({tag, "_lane1"}, 64'(bus.out_lane1), 64'(l1));
    check({tag, "_sat"},   64'(bus.out_sat),   64'(s));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ap_ce     = 1'b1;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    check_out("rst", 1'b0, 0, 0, 2'b00);
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    ap_rst_n = 1'b1;
    tick();

    // len=4: 1..4 and -1..-4
    bus.len = 16'd4;
    for (int i = 1; i <= 4; i++) begin
      beat(24'(i), 24'(-i), waits);
      if (i < 4) check("t1_novalid", 64'(bus.out_valid), 64'(0));
    end
    check_out("t1", 1'b1, 10, -10, 2'b00);
    tick();
    check("t1_pulse", 64'(bus.out_valid), 64'(0));

    // Positive saturation on lane 0, then a clean frame, then negative saturation on both
    bus.len = 16'd3;
    for (int i = 0; i < 3; i++) beat(24'h7FFFFF, 24'sd1, waits);
    check_out("t2pos", 1'b1, 16777215, 3, 2'b01);
    for (int i = 1; i <= 3; i++) beat(24'(i), 24'(0), waits);
    check_out("t2clr", 1'b1, 6, 0, 2'b00);
    for (int i = 0; i < 3; i++) beat(24'h800000, 24'h800000, waits);
    check_out("t2neg", 1'b1, -16777216, -16777216, 2'b11);
    tick();

    // len=2 with downstream stalled: A held, B's last beat stalls until out_ready
    bus.out_ready = 1'b0;
    bus.len = 16'd2;
    beat(24'sd5, 24'sd6, waits);
    beat(24'sd7, 24'sd8, waits);
    check_out("t3A", 1'b1, 12, 14, 2'b00);
    beat(24'sd1, 24'sd1, waits);
    check("t3_b1_nostall", 64'(waits), 64'(0));
    bus.in_valid = 1'b1;
    bus.in_data  = {24'sd2, 24'sd3};
    #1;
    check("t3_stall0", 64'(bus.in_ready), 64'(0));
    @(posedge ap_clk);
    #1;
    check("t3_hold_lane0", 64'(bus.out_lane0), 64'(12));
    check("t3_stall1", 64'(bus.in_ready), 64'(0));
    bus.out_ready = 1'b1;
    #1;
    check("t3_release", 64'(bus.in_ready), 64'(1));
    @(posedge ap_clk);
    #1;
    bus.in_valid = 1'b0;
    check_out("t3B", 1'b1, 3, 4, 2'b00);
    tick();
    check("t3_drained", 64'(bus.out_valid), 64'(0));

    // len=1 back-to-back: one result per cycle
    bus.len = 16'd1;
    for (int i = 0; i < 8; i++) begin
      beat(24'(i), 24'(-i), waits);
      check("t4_nobubble", 64'(waits), 64'(0));
      check("t4_valid", 64'(bus.out_valid), 64'(1));
      check("t4_lane0", 64'(bus.out_lane0), 64'(i));
      check("t4_lane1", 64'(bus.out_lane1), 64'(-i));
    end
    tick();
    check("t4_drained", 64'(bus.out_valid), 64'(0));

    // Asynchronous reset mid-frame with a result pending
    bus.out_ready = 1'b0;
    bus.len = 16'd1;
    beat(24'sd100, -24'sd100, waits);
    bus.len = 16'd5;
    for (int i = 0; i < 3; i++) beat(24'sd9, 24'sd9, waits);
    check("t5_held", 64'(bus.out_lane0), 64'(100));
    #3;
    ap_rst_n = 1'b0;
    #1;
    check_out("t5rst", 1'b0, 0, 0, 2'b00);
    check("t5_in_ready", 64'(bus.in_ready), 64'(1));
    #2;
    ap_rst_n = 1'b1;
    tick();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) beat(24'sd2, 24'sd2, waits);
    check_out("t5", 1'b1, 10, 10, 2'b00);
    tick();

    // ap_ce gap with len change and an output transfer inside the gap
    bus.out_ready = 1'b0;
    bus.len = 16'd1;
    beat(24'sd50, 24'sd60, waits);
    bus.len = 16'd3;
    beat(24'sd1, 24'sd1, waits);
    check("t6_b1_nostall", 64'(waits), 64'(0));
    bus.ap_ce = 1'b0;
    bus.len   = 16'd7;
    for (int g = 0; g < 4; g++) begin
      #1;
      check("t6_gap_ready", 64'(bus.in_ready), 64'(0));
      if (g == 1) bus.out_ready = 1'b1;
      @(posedge ap_clk);
      #1;
    end
    check("t6_gap_xfer", 64'(bus.out_valid), 64'(0));
    bus.ap_ce = 1'b1;
    beat(24'sd2, 24'sd2, waits);
    beat(24'sd3, 24'sd3, waits);
    check_out("t6", 1'b1, 6, 6, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
